// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arb_pkg
// Description : Shared types and width helpers for the round-robin lock
//               arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Index width for a requester vector of n entries (n is a power of 2, >= 2)
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_lock_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : rr_lock_arbiter_if
// Description : Request/grant bundle between requester front-ends and the
//               round-robin lock arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_lock_arbiter_if
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
);
  localparam int IDX_W = idx_w(N_REQ);
  localparam int HC_W  = $clog2(MAX_HOLD + 1);

  logic [N_REQ-1:0] req;
  logic             en;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             busy;
  logic [IDX_W-1:0] ptr;
  logic [HC_W-1:0]  hold_cnt;

  // Requester side: drives requests, observes grant state
  modport master (
    output req, en,
    input  gnt, gnt_idx, busy, ptr, hold_cnt
  );

  // Arbiter side
  modport slave (
    input  req, en,
    output gnt, gnt_idx, busy, ptr, hold_cnt
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority picker. Finds the first set
//               request scanning from ptr upward, wrapping modulo N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  wire logic [N_REQ-1:0] req,
  input  wire logic [IDX_W-1:0] ptr,
  output logic                  valid,
  output logic [IDX_W-1:0]      idx,
  output logic [N_REQ-1:0]      onehot
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;

  // Rotate so ptr lands at bit 0, fixed-priority pick, then rotate the index back
  always_comb begin
    w_dbl  = {req, req};
    w_rot  = w_dbl[ptr +: N_REQ];
    valid  = |req;
    w_off  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = i[IDX_W-1:0];
    end
    // Modular add: N_REQ is a power of 2, so overflow is the wrap
    idx    = ptr + w_off;
    onehot = '0;
    if (valid) onehot[idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_lock_arbiter
// Description : Round-robin arbiter with a transaction-long grant lock,
//               hold-limit preemption and a single turnaround cycle between
//               owners. Priority pointer follows the last owner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  wire logic           clock,
  input  wire logic           reset,
  rr_lock_arbiter_if.slave    bus
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int HC_W  = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] c_MAX_HOLD = HC_W'(MAX_HOLD);

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_busy;
  logic [IDX_W-1:0] r_ptr;
  logic [HC_W-1:0]  r_hold;

  logic             w_valid;
  logic [IDX_W-1:0] w_idx;
  logic [N_REQ-1:0] w_onehot;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (bus.req),
    .ptr    (r_ptr),
    .valid  (w_valid),
    .idx    (w_idx),
    .onehot (w_onehot)
  );

  // Arbitration FSM: grant lock, hold counting, preemption and pointer advance
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_busy    <= 1'b0;
      r_ptr     <= '0;
      r_hold    <= '0;
    end else begin
      case (r_state)
        IDLE, TURN: begin
          if (bus.en && w_valid) begin
            r_state   <= GRANT;
            r_gnt     <= w_onehot;
            r_gnt_idx <= w_idx;
            r_busy    <= 1'b1;
            r_hold    <= HC_W'(1);
          end else begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_hold  <= '0;
          end
        end
        GRANT: begin
          // Release and preemption take the same path: one TURN cycle,
          // and the owner drops to lowest priority
          if (!bus.req[r_gnt_idx] || (r_hold == c_MAX_HOLD)) begin
            r_state <= TURN;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_hold  <= '0;
            r_ptr   <= r_gnt_idx + IDX_W'(1);
          end else begin
            r_hold <= r_hold + HC_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_hold  <= '0;
        end
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.gnt_idx  = r_gnt_idx;
  assign bus.busy     = r_busy;
  assign bus.ptr      = r_ptr;
  assign bus.hold_cnt = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_lock_arbiter
// Description : Scoreboard bench for rr_lock_arbiter: directed vectors with
//               hand-derived expectations plus a random invariant phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_lock_arbiter;

  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 8;
  localparam int c_STARVE = N_REQ * (MAX_HOLD + 1);

  logic clock;
  logic reset;

  rr_lock_arbiter_if #(.N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD)) bus ();

  rr_lock_arbiter #(
    .N_REQ    (N_REQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Expected packing: {gnt[3:0], gnt_idx[1:0], busy, ptr[1:0], hold_cnt[3:0]}
  logic [12:0] exp_q[$];
  string       name_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          rnd_on   = 1'b0;
  int          wcnt[N_REQ];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one cycle of stimulus and queue the state expected after the edge
  task automatic step(input logic [3:0] r, input logic e, input logic rs,
                      input logic [3:0] g, input logic [1:0] gi, input logic b,
                      input logic [1:0] p, input logic [3:0] h, input string nm);
    @(negedge clock);
    bus.req = r;
    bus.en  = e;
    reset   = rs;
    exp_q.push_back({g, gi, b, p, h});
    name_q.push_back(nm);
    @(posedge clock);
  endtask

  // Scoreboard monitor: compare the post-edge state against the queued entry
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      logic [12:0] a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus.gnt, bus.gnt_idx, bus.busy, bus.ptr, bus.hold_cnt};
      // gnt_idx only carries meaning while busy
      if (!e[6]) a[8:7] = e[8:7];
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got gnt=%b idx=%0d busy=%b ptr=%0d hold=%0d, want gnt=%b idx=%0d busy=%b ptr=%0d hold=%0d",
                 nm, a[12:9], a[8:7], a[6], a[5:4], a[3:0],
                 e[12:9], e[8:7], e[6], e[5:4], e[3:0]);
      end
    end
  end

  // Invariant monitor: one-hot grant, busy tracks grant, bounded waiting
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      checks++;
      if (!$onehot0(bus.gnt)) begin
        failures++;
        $display("FAIL onehot: got gnt=%b, want one-hot or zero", bus.gnt);
      end
      checks++;
      if (bus.busy !== (|bus.gnt)) begin
        failures++;
        $display("FAIL busy_eq: got busy=%b, want %b", bus.busy, |bus.gnt);
      end
    end
    if (rnd_on) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!bus.req[i] || bus.gnt[i]) wcnt[i] = 0;
        else if (bus.en) wcnt[i]++;
        checks++;
        if (wcnt[i] > c_STARVE) begin
          failures++;
          $display("FAIL starve: requester %0d waited %0d cycles, want <= %0d", i, wcnt[i], c_STARVE);
          wcnt[i] = 0;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, want finish before 1000000");
    $fatal(1, "timeout");
  end

  // Directed stimulus followed by random traffic
  initial begin
    logic [3:0] r;
    bus.req = '0;
    bus.en  = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < N_REQ; i++) wcnt[i] = 0;

    // Reset state
    step(4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0, 4'd0, "reset");

    // Basic grant, release, turnaround, next owner, pointer wrap
    step(4'b1010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd0, 4'd1, "t1_grant");
    step(4'b1000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd2, 4'd0, "t1_turn");
    step(4'b1000, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd2, 4'd1, "t1_next");
    step(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 4'd0, "t1_wrap");
    step(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 4'd0, "t1_idle");

    // All requesting: 8-cycle tenures, one TURN each, order 0,1,2,3,0
    for (int o = 0; o < 5; o++) begin
      for (int c = 1; c <= MAX_HOLD; c++)
        step(4'b1111, 1'b1, 1'b0, 4'(1 << (o % 4)), 2'(o % 4), 1'b1, 2'(o % 4), 4'(c), "t2_hold");
      step((o == 4) ? 4'b0000 : 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'((o + 1) % 4), 4'd0, "t2_turn");
    end
    step(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1, 4'd0, "t2_idle");

    // Sole requester: preempted, re-granted with hold restarting, then reset mid-grant
    for (int c = 1; c <= MAX_HOLD; c++)
      step(4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd1, 4'(c), "t3_hold");
    step(4'b0100, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd3, 4'd0, "t3_turn");
    step(4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd3, 4'd1, "t3_regrant");
    for (int c = 2; c <= 5; c++)
      step(4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd3, 4'(c), "t3_rehold");
    step(4'b0100, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0, 4'd0, "t5_reset");
    step(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 4'd0, "t5_idle");

    // Enable gating: no new grant while low, but an existing grant is kept
    for (int c = 0; c < 3; c++)
      step(4'b0001, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0, 4'd0, "t4_en_low");
    step(4'b0001, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd0, 4'd1, "t4_grant");
    step(4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd0, 4'd2, "t4_keep");
    step(4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd0, 4'd3, "t4_keep");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1, 4'd0, "t4_release");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1, 4'd0, "t4_idle");

    // Random sticky requests with mostly-high enable
    @(negedge clock);
    rnd_on = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clock);
      r = bus.req;
      for (int i = 0; i < N_REQ; i++)
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      bus.req = r;
      bus.en  = ($urandom_range(0, 9) != 0);
    end
    @(negedge clock);
    rnd_on = 1'b0;

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
